// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE 16-bit core: FSM states, instruction
// fields and flag bit positions.
package simple_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  localparam logic [3:0] OP3_CMP     = 4'b0101;
  localparam logic [3:0] OP3_ALU_MAX = 4'b1011;
  localparam logic [3:0] OP3_HLT     = 4'b1111;

  localparam logic [2:0] OP2_LI  = 3'b000;
  localparam logic [2:0] OP2_B   = 3'b100;
  localparam logic [2:0] OP2_BCC = 3'b111;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALU/shift group of op=11 updates the flag register; IN/OUT/HLT do not.
  function automatic logic is_alu_op3(input logic [3:0] op3);
    return (op3 <= OP3_ALU_MAX);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch resolver: maps a 3-bit condition code and the SZCV
// flags to a taken decision.
module branch_cond
  import simple_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic lt_s;

  assign lt_s = flags[FLAG_S] ^ flags[FLAG_V];

  // Decode the condition code; unused codes are never taken.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BE:  taken = flags[FLAG_Z];
      COND_BLT: taken = lt_s;
      COND_BLE: taken = flags[FLAG_Z] | lt_s;
      COND_BNE: taken = ~flags[FLAG_Z];
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/phase_controller.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the SIMPLE
// core; owns every datapath strobe and the architectural SZCV flag register.
module phase_controller
  import simple_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir_data,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel_pc,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_read,
  output logic        alu_latch,
  output logic        reg_write,
  output logic        wb_sel_mem,
  output logic [3:0]  flags,
  output logic        halted,
  output logic [2:0]  state
);

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  logic [3:0] flags_r;
  logic [1:0] op_s;
  logic [2:0] op2_s;
  logic [2:0] cond_s;
  logic [3:0] op3_s;
  logic       is_alu_s;
  logic       taken_s;
  logic       unused_ir_s;

  assign op_s        = ir_data[15:14];
  assign op2_s       = ir_data[13:11];
  assign cond_s      = ir_data[10:8];
  assign op3_s       = ir_data[7:4];
  assign unused_ir_s = ^ir_data[3:0];
  assign is_alu_s    = (op_s == OP_ALU) && is_alu_op3(op3_s);

  branch_cond u_branch_cond (
    .cond  (cond_s),
    .flags (flags_r),
    .taken (taken_s)
  );

  // State and flag registers; reset dominates every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      flags_r <= 4'b0000;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_EXEC) && is_alu_s) begin
        flags_r <= alu_flags;
      end else begin
        flags_r <= flags_r;
      end
    end
  end

  // Next-state selection; IR is stable from DECODE onward.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: next_state_s = ST_EXEC;
      ST_EXEC: begin
        case (op_s)
          OP_ALU: begin
            if (is_alu_s) begin
              next_state_s = (op3_s == OP3_CMP) ? ST_FETCH : ST_WB;
            end else if (op3_s == OP3_HLT) begin
              next_state_s = ST_HALT;
            end else begin
              next_state_s = ST_FETCH;
            end
          end
          OP_LD, OP_ST: next_state_s = ST_MEM;
          OP_BR: next_state_s = (op2_s == OP2_LI) ? ST_WB : ST_FETCH;
          default: next_state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          next_state_s = (op_s == OP_LD) ? ST_WB : ST_FETCH;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = run ? ST_FETCH : ST_HALT;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Strobe decode from the registered state; only FETCH handshakes qualify on mem_ready.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel_pc = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    reg_read    = 1'b0;
    alu_latch   = 1'b0;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    halted      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req     = 1'b1;
        addr_sel_pc = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end else begin
          ir_load = 1'b0;
          pc_inc  = 1'b0;
        end
      end
      ST_DECODE: reg_read = 1'b1;
      ST_EXEC: begin
        case (op_s)
          OP_ALU:       alu_latch = is_alu_s;
          OP_LD, OP_ST: alu_latch = 1'b1;
          OP_BR: begin
            if (op2_s == OP2_B) begin
              pc_load = 1'b1;
            end else if (op2_s == OP2_BCC) begin
              pc_load = taken_s;
            end else begin
              pc_load = 1'b0;
            end
          end
          default: alu_latch = 1'b0;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_s == OP_ST);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel_mem = (op_s == OP_LD);
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign flags = flags_r;
  assign state = state_r;

endmodule
